// File: rtl/vfd_scan_sched.sv
// -----------------------------------------------------------------------------
// vfd_scan_sched -- grid-scan scheduler for the VFD refresh path.
//
// Owns the per-grid refresh slot: BLK/LAT pulse sequence, grid number (GN)
// sequencing, the Tri-SPI shifter enable window and bit index, the GCP
// grayscale pulses, and the GRAM front/back bank swap handshake.
//
// Every output is registered and shows the value that belongs to the slot
// position currently held in the slot counter (t_q). To get that alignment,
// the output registers are loaded from the *next* counter value (t_d).
//
// Ports
//   clk_i           system clock (posedge)
//   rstn_i          synchronous active-low reset
//   en_i            scan enable (level)
//   swap_req_i      host bank-swap request (level, held until swap_ack_o)
//   blk_o           display blanking
//   lat_o           serial latch
//   sce_o           shifter enable window
//   bit_idx_o[8:0]  shifter bit index while sce_o, else 0
//   gn_o[5:0]       current grid number (1..GRID_COUNT, 0 after reset)
//   gcp_o           gradient control pulse
//   frame_start_o   one-cycle strobe on the first slot of each frame
//   buf_sel_o       GRAM bank being displayed
//   swap_ack_o      one-cycle swap acknowledge
//
// Parameter legality: SLOT_CYCLES >= LAT_WIDTH + 3 + BITS_PER_GRID,
// BITS_PER_GRID <= 512, GRID_COUNT <= 63.
// -----------------------------------------------------------------------------
module vfd_scan_sched #(
  parameter int GRID_COUNT    = 52,
  parameter int SLOT_CYCLES   = 3840,
  parameter int BITS_PER_GRID = 288,
  parameter int LAT_WIDTH     = 5
) (
  input  logic       clk_i,
  input  logic       rstn_i,
  input  logic       en_i,
  input  logic       swap_req_i,
  output logic       blk_o,
  output logic       lat_o,
  output logic       sce_o,
  output logic [8:0] bit_idx_o,
  output logic [5:0] gn_o,
  output logic       gcp_o,
  output logic       frame_start_o,
  output logic       buf_sel_o,
  output logic       swap_ack_o
);

  localparam int TW = $clog2(SLOT_CYCLES);

  // Slot positions, pre-sized to the counter width so every compare is exact.
  localparam logic [TW-1:0] T_ONE       = TW'(1);
  localparam logic [TW-1:0] T_LAST      = TW'(SLOT_CYCLES - 1);
  localparam logic [TW-1:0] T_LAT_END   = TW'(LAT_WIDTH);
  localparam logic [TW-1:0] T_BLK_END   = TW'(LAT_WIDTH + 1);
  localparam logic [TW-1:0] T_SCE_BEGIN = TW'(LAT_WIDTH + 2);
  localparam logic [TW-1:0] T_SCE_END   = TW'(LAT_WIDTH + 1 + BITS_PER_GRID);
  localparam logic [5:0]    GN_LAST     = 6'(GRID_COUNT);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  state_e          state_q, state_d;
  logic [TW-1:0]   t_q, t_d;
  logic [5:0]      gn_q, gn_d;
  logic            blk_q, blk_d;
  logic            lat_q, lat_d;
  logic            sce_q, sce_d;
  logic [8:0]      bit_idx_q, bit_idx_d;
  logic            gcp_q, gcp_d;
  logic            fs_q, fs_d;
  logic            buf_q, buf_d;
  logic            ack_q, ack_d;
  // Set once swap_req_i has been seen low since the last acknowledge, so a
  // requester that keeps the level high after ACK cannot trigger a re-swap.
  logic            armed_q, armed_d;

  logic            new_slot;
  logic            gn_wrap;
  logic            running;

  // ---------------------------------------------------------------------------
  // Next-state and output decode
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal written here gets a default first; a path that leaves
    // one unassigned would infer a latch.
    state_d   = state_q;
    t_d       = t_q;
    gn_d      = gn_q;
    new_slot  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (en_i) begin
          state_d  = RUN;
          t_d      = '0;
          new_slot = 1'b1;
        end
      end
      RUN: begin
        if (t_q == T_LAST) begin
          // The running slot always completes; EN only decides whether the
          // next one starts.
          t_d = '0;
          if (en_i) begin
            new_slot = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end else begin
          t_d = t_q + T_ONE;
        end
      end
      default: begin
        state_d = IDLE;
        t_d     = '0;
      end
    endcase

    // GN == 0 only right after reset; it then jumps straight to grid 1.
    gn_wrap = (gn_q == '0) || (gn_q >= GN_LAST);
    if (new_slot) begin
      gn_d = gn_wrap ? 6'd1 : gn_q + 6'd1;
    end

    fs_d    = new_slot && gn_wrap;
    ack_d   = fs_d && swap_req_i && armed_q;
    buf_d   = buf_q ^ ack_d;
    armed_d = ack_d ? 1'b0 : (armed_q | ~swap_req_i);

    running = (state_d == RUN);
    blk_d   = running && (t_d <= T_BLK_END);
    lat_d   = running && (t_d >= T_ONE) && (t_d <= T_LAT_END);
    sce_d   = running && (t_d >= T_SCE_BEGIN) && (t_d <= T_SCE_END);

    // The SCE window is contiguous and always entered at T_SCE_BEGIN, so the
    // bit index is a plain counter that restarts on the window's first cycle.
    if (!sce_d) begin
      bit_idx_d = '0;
    end else if (!sce_q) begin
      bit_idx_d = '0;
    end else begin
      bit_idx_d = bit_idx_q + 9'd1;
    end

    gcp_d = sce_d && (bit_idx_d inside {9'd72, 9'd144, 9'd192, 9'd216, 9'd240, 9'd256});
  end

  // ---------------------------------------------------------------------------
  // State and output registers
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge value of every other register.
  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      state_q   <= IDLE;
      t_q       <= '0;
      gn_q      <= '0;
      blk_q     <= 1'b0;
      lat_q     <= 1'b0;
      sce_q     <= 1'b0;
      bit_idx_q <= '0;
      gcp_q     <= 1'b0;
      fs_q      <= 1'b0;
      buf_q     <= 1'b0;
      ack_q     <= 1'b0;
      armed_q   <= 1'b1;
    end else begin
      state_q   <= state_d;
      t_q       <= t_d;
      gn_q      <= gn_d;
      blk_q     <= blk_d;
      lat_q     <= lat_d;
      sce_q     <= sce_d;
      bit_idx_q <= bit_idx_d;
      gcp_q     <= gcp_d;
      fs_q      <= fs_d;
      buf_q     <= buf_d;
      ack_q     <= ack_d;
      armed_q   <= armed_d;
    end
  end

  assign blk_o         = blk_q;
  assign lat_o         = lat_q;
  assign sce_o         = sce_q;
  assign bit_idx_o     = bit_idx_q;
  assign gn_o          = gn_q;
  assign gcp_o         = gcp_q;
  assign frame_start_o = fs_q;
  assign buf_sel_o     = buf_q;
  assign swap_ack_o    = ack_q;

endmodule

// File: tb/tb_vfd_scan_sched.sv
// -----------------------------------------------------------------------------
// tb_vfd_scan_sched -- self-checking bench for vfd_scan_sched.
//
// The DUT runs with a shortened slot (SLOT_CYCLES=300) and frame
// (GRID_COUNT=8) so whole frames fit in a short run; the pulse positions
// inside the slot (LAT 1..5, SCE 7..294, GCP at 79..263) are unchanged.
//
// A reference model derived from the slot rules (position in slot, grid
// number, swap eligibility) is stepped on every posedge and compared with all
// DUT outputs on every negedge. On top of that, a table of slot positions and
// several hand-written sequences check the timing and handshake corners
// against constants.
// -----------------------------------------------------------------------------
module tb_vfd_scan_sched;

  localparam int G    = 8;
  localparam int SLOT = 300;
  localparam int BITS = 288;
  localparam int LAT  = 5;

  logic       clk;
  logic       rstn;
  logic       en;
  logic       swap_req;
  logic       blk, lat, sce, gcp, fs, buf_sel, ack;
  logic [8:0] bit_idx;
  logic [5:0] gn;

  vfd_scan_sched #(
    .GRID_COUNT   (G),
    .SLOT_CYCLES  (SLOT),
    .BITS_PER_GRID(BITS),
    .LAT_WIDTH    (LAT)
  ) dut (
    .clk_i        (clk),
    .rstn_i       (rstn),
    .en_i         (en),
    .swap_req_i   (swap_req),
    .blk_o        (blk),
    .lat_o        (lat),
    .sce_o        (sce),
    .bit_idx_o    (bit_idx),
    .gn_o         (gn),
    .gcp_o        (gcp),
    .frame_start_o(fs),
    .buf_sel_o    (buf_sel),
    .swap_ack_o   (ack)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s @cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: position within the slot (-1 = idle), grid number, bank,
  // and whether the request has been seen low since the last acknowledge.
  // ---------------------------------------------------------------------------
  int m_pos   = -1;
  int m_gn    = 0;
  bit m_buf   = 1'b0;
  bit m_fs    = 1'b0;
  bit m_ack   = 1'b0;
  bit m_low   = 1'b1;

  always @(posedge clk) begin
    if (!rstn) begin
      m_pos = -1;
      m_gn  = 0;
      m_buf = 1'b0;
      m_fs  = 1'b0;
      m_ack = 1'b0;
      m_low = 1'b1;
    end else begin
      m_fs  = 1'b0;
      m_ack = 1'b0;
      if (en && (m_pos == -1 || m_pos == SLOT - 1)) begin
        m_pos = 0;
        m_gn  = (m_gn >= 1 && m_gn < G) ? m_gn + 1 : 1;
        m_fs  = (m_gn == 1);
        if (m_fs && swap_req && m_low) begin
          m_buf = ~m_buf;
          m_ack = 1'b1;
          m_low = 1'b0;
        end
      end else if (m_pos == SLOT - 1) begin
        m_pos = -1;
      end else if (m_pos >= 0) begin
        m_pos = m_pos + 1;
      end
      if (!swap_req) m_low = 1'b1;
    end
  end

  function automatic logic [21:0] model_out();
    int  gcp_pts[6] = '{72, 144, 192, 216, 240, 256};
    bit  e_blk = 0, e_lat = 0, e_sce = 0, e_gcp = 0;
    int  e_idx = 0;
    if (m_pos >= 0) begin
      e_blk = (m_pos <= LAT + 1);
      e_lat = (m_pos >= 1 && m_pos <= LAT);
      e_sce = (m_pos >= LAT + 2 && m_pos <= LAT + 1 + BITS);
      if (e_sce) begin
        e_idx = m_pos - (LAT + 2);
        foreach (gcp_pts[k]) if (gcp_pts[k] == e_idx) e_gcp = 1;
      end
    end
    return {e_blk, e_lat, e_sce, e_gcp, 9'(e_idx), 6'(m_gn), m_fs, m_buf, m_ack};
  endfunction

  function automatic logic [21:0] dut_out();
    return {blk, lat, sce, gcp, bit_idx, gn, fs, buf_sel, ack};
  endfunction

  // Event counters stepped by tick(); sequences zero them as needed.
  int cnt_fs, cnt_ack, cnt_gcp, cnt_sce;

  // One clock: wait for the sampling edge, compare against the model, count.
  task automatic tick();
    @(negedge clk);
    cyc++;
    check("lockstep", 32'(dut_out()), 32'(model_out()));
    cnt_fs  += int'(fs);
    cnt_ack += int'(ack);
    cnt_gcp += int'(gcp);
    cnt_sce += int'(sce);
  endtask

  task automatic next_slot();
    repeat (SLOT) tick();
  endtask

  task automatic do_reset();
    rstn     = 1'b0;
    en       = 1'b0;
    swap_req = 1'b0;
    repeat (2) tick();
    check("reset_state", 32'(dut_out()), 32'd0);
    rstn = 1'b1;
  endtask

  typedef struct {
    int   t;
    logic blk;
    logic lat;
    logic sce;
    logic gcp;
    int   idx;
  } vec_t;

  vec_t tbl[$];

  initial begin
    int cur;
    rstn     = 1'b0;
    en       = 1'b0;
    swap_req = 1'b0;

    // Slot-position table: {T, BLK, LAT, SCE, GCP, BIT_IDX}
    tbl.push_back('{0,   1, 0, 0, 0, 0});
    tbl.push_back('{1,   1, 1, 0, 0, 0});
    tbl.push_back('{5,   1, 1, 0, 0, 0});
    tbl.push_back('{6,   1, 0, 0, 0, 0});
    tbl.push_back('{7,   0, 0, 1, 0, 0});
    tbl.push_back('{78,  0, 0, 1, 0, 71});
    tbl.push_back('{79,  0, 0, 1, 1, 72});
    tbl.push_back('{80,  0, 0, 1, 0, 73});
    tbl.push_back('{151, 0, 0, 1, 1, 144});
    tbl.push_back('{199, 0, 0, 1, 1, 192});
    tbl.push_back('{223, 0, 0, 1, 1, 216});
    tbl.push_back('{247, 0, 0, 1, 1, 240});
    tbl.push_back('{263, 0, 0, 1, 1, 256});
    tbl.push_back('{264, 0, 0, 1, 0, 257});
    tbl.push_back('{294, 0, 0, 1, 0, 287});
    tbl.push_back('{295, 0, 0, 0, 0, 0});
    tbl.push_back('{299, 0, 0, 0, 0, 0});

    // --- Slot timing after reset release with EN steady --------------------
    do_reset();
    en = 1'b1;
    tick();
    check("first_gn", 32'(gn), 32'd1);
    check("first_fs", 32'(fs), 32'd1);
    cnt_gcp = 0;
    cnt_sce = 0;
    cur = 0;
    for (int i = 0; i < tbl.size(); i++) begin
      while (cur < tbl[i].t) begin
        tick();
        cur++;
      end
      check($sformatf("slot_t%0d", tbl[i].t), {27'd0, blk, lat, sce, gcp, bit_idx},
            {27'd0, tbl[i].blk, tbl[i].lat, tbl[i].sce, tbl[i].gcp, 9'(tbl[i].idx)});
    end
    check("gcp_per_slot", 32'(cnt_gcp), 32'd6);
    check("sce_per_slot", 32'(cnt_sce), 32'(BITS));
    tick();
    check("slot2_gn", 32'(gn), 32'd2);
    check("slot2_blk_fs", {30'd0, blk, fs}, 32'b10);

    // --- GN sequence over a full frame plus one slot -----------------------
    do_reset();
    en = 1'b1;
    cnt_fs = 0;
    tick();
    for (int s = 1; s <= G + 1; s++) begin
      check($sformatf("gn_seq_slot%0d", s), 32'(gn), 32'(((s - 1) % G) + 1));
      if (s <= G) next_slot();
    end
    check("frame_start_count", 32'(cnt_fs), 32'd2);

    // --- Swap handshake ----------------------------------------------------
    do_reset();
    en = 1'b1;
    cnt_ack = 0;
    tick();                              // GN=1, T=0
    repeat (2) next_slot();              // GN=3, T=0
    repeat (50) tick();
    swap_req = 1'b1;
    repeat (SLOT - 50) tick();           // GN=4, T=0
    repeat (G - 3) next_slot();          // GN=1, T=0
    check("swap1_gn", 32'(gn), 32'd1);
    check("swap1_ack_buf", {30'd0, ack, buf_sel}, 32'b11);
    tick();
    check("swap1_ack_drop", 32'(ack), 32'd0);
    repeat (G * SLOT - 1) tick();        // next boundary, request still high
    check("held_req_no_reswap", {30'd0, ack, buf_sel}, 32'b01);
    repeat (10) tick();
    swap_req = 1'b0;
    tick();
    swap_req = 1'b1;
    repeat (G * SLOT - 11) tick();       // next boundary after release
    check("swap2_ack_buf", {30'd0, ack, buf_sel}, 32'b10);
    swap_req = 1'b0;
    tick();
    check("ack_total", 32'(cnt_ack), 32'd2);

    // --- EN dropped mid-slot -----------------------------------------------
    do_reset();
    en = 1'b1;
    tick();
    repeat (4) next_slot();              // GN=5, T=0
    cnt_sce = 0;
    repeat (100) tick();
    en = 1'b0;
    repeat (SLOT - 1 - 100) tick();
    check("en_drop_sce_full", 32'(cnt_sce), 32'(BITS));
    tick();
    check("en_drop_idle_pulses", {27'd0, blk, lat, sce, gcp, bit_idx}, 32'd0);
    check("en_drop_gn_hold", 32'(gn), 32'd5);
    repeat (20) tick();
    check("idle_gn_hold", 32'(gn), 32'd5);
    en = 1'b1;
    tick();
    check("reenable_gn", 32'(gn), 32'd6);
    check("reenable_blk_fs", {30'd0, blk, fs}, 32'b10);

    // --- Reset mid-SCE, with the non-default bank selected -----------------
    do_reset();
    swap_req = 1'b1;
    en       = 1'b1;
    tick();
    check("first_frame_swap", {30'd0, ack, buf_sel}, 32'b11);
    swap_req = 1'b0;
    repeat (150) tick();
    check("mid_sce", 32'(sce), 32'd1);
    rstn = 1'b0;
    tick();
    check("midslot_reset", 32'(dut_out()), 32'd0);
    rstn = 1'b1;
    tick();
    check("post_reset_gn", 32'(gn), 32'd1);
    check("post_reset_buf_fs", {30'd0, fs, buf_sel}, 32'b10);

    // --- Randomized run against the model ---------------------------------
    do_reset();
    en = 1'b1;
    for (int i = 0; i < 15000; i++) begin
      tick();
      if ($urandom_range(0, 499) == 0) en = ~en;
      if ($urandom_range(0, 299) == 0) swap_req = ~swap_req;
      rstn = ($urandom_range(0, 3999) != 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
